ahb3lite_gpio: RTL and testbench
================================

AHB3LITE_GPIO -- requirements
Module: ahb3lite_gpio

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  HADDR_SIZE, 32, AHB address width.
  HDATA_SIZE, 32, AHB data width (32 only).
  GPIO_WIDTH, 8, pin channel count (1..32).
  SYNC_STAGES, 2, input synchroniser depth (>=2).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  HCLK  in  1  single clock; all logic on rising edge.
  HRESETn  in  1  asynchronous, active-low reset.
  HSEL  in  1  slave select.
  HADDR  in  HADDR_SIZE  address; only HADDR[4:0] decoded.
  HWDATA  in  HDATA_SIZE  write data (data phase).
  HRDATA  out  HDATA_SIZE  read data (data phase).
  HWRITE  in  1  1=write.
  HSIZE  in  3  0=byte, 1=halfword, 2=word.
  HBURST  in  3  ignored.
  HPROT  in  4  ignored.
  HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  HREADYOUT  out  1  slave ready.
  HREADY  in  1  bus ready.
  HRESP  out  1  response; OKAY=0.
  gpio_i  in  GPIO_WIDTH  asynchronous pin inputs.
  gpio_o  out  GPIO_WIDTH  pin output values.
  gpio_oe  out  GPIO_WIDTH  per-pin output enable.
  irq_o  out  1  level interrupt.

Function
REQ-003 Address phase accepted when HSEL & HREADY & HTRANS[1]; HADDR[4:2], HSIZE, HADDR[1:0], HWRITE registered for the data phase; BUSY/IDLE SHALL cause no access.
REQ-004 HREADYOUT SHALL be 1 and HRESP 0 on every cycle (zero wait state, no errors).
REQ-005 Register map, word offsets: 0x00 DOUT rw; 0x04 DIN ro; 0x08 DIR rw; 0x0C SET wo; 0x10 CLR wo; 0x14 TGL wo; 0x18 IEN rw; 0x1C ISTAT rw1c.
REQ-006 Writes SHALL commit at the end of the data phase using HWDATA; only byte lanes selected by registered HSIZE/HADDR[1:0] SHALL be affected; bits >= GPIO_WIDTH ignored.
REQ-007 SET: DOUT |= wdata; CLR: DOUT &= ~wdata; TGL: DOUT ^= wdata; all single-cycle, reading SET/CLR/TGL SHALL return 0.
REQ-008 Reads SHALL drive HRDATA combinationally in the data phase from registered offset, zero-extended above GPIO_WIDTH; HRDATA SHALL be 0 outside a read data phase.
REQ-009 DIN SHALL be gpio_i through SYNC_STAGES flops; read latency from pin to DIN is SYNC_STAGES cycles.
REQ-010 Edge detect: rise[i] = sync[i] & ~sync_d[i], one extra flop; rise[i] SHALL set ISTAT[i] regardless of IEN.
REQ-011 ISTAT write SHALL clear bits written 1; a rise on the same cycle as a clear of that bit SHALL leave the bit set (set wins).
REQ-012 irq_o SHALL be registered: |(ISTAT & IEN), updating one cycle after ISTAT/IEN change.
REQ-013 gpio_o = DOUT, gpio_oe = DIR, both direct register outputs.
REQ-014 Back-to-back transfers SHALL be supported: write data phase overlapping next address phase; a read of a register immediately after a write to it SHALL return the new value.
REQ-015 Unmapped offsets do not exist (8 slots fully mapped); writes to DIN SHALL be ignored.

Reset
REQ-016 On HRESETn low, asynchronously: DOUT, DIR, IEN, ISTAT, synchroniser and edge flops, registered address phase, irq_o all 0; gpio_o=0, gpio_oe=0, HRDATA=0.
REQ-017 Reset mid-transfer SHALL abort the pending data phase with no register update; after release first accepted transfer behaves normally.
REQ-018 Synchroniser/edge flops reset to 0, so a pin already high at release SHALL produce one rise and set ISTAT after SYNC_STAGES+1 cycles.

Verification
REQ-019 Word write 0xA5 to DOUT, DIR=0xFF -> gpio_o=0xA5, gpio_oe=0xFF next cycle; read DOUT returns 0x000000A5.
REQ-020 DOUT=0xF0; SET 0x01, CLR 0x80, TGL 0x0F back-to-back -> DOUT 0xF1, 0x71, 0x7E after successive cycles.
REQ-021 Byte write 0x3C at offset 0x00+1 -> DOUT bits[15:8]=0x3C, bits[7:0] unchanged.
REQ-022 gpio_i[3] 0->1, IEN=0x08 -> ISTAT=0x08 after 3 cycles, irq_o=1 one cycle later; write 0x08 to ISTAT -> irq_o=0.
REQ-023 Rise on pin 2 in same cycle as ISTAT write 0x04 -> ISTAT[2] remains 1.
REQ-024 Assert HRESETn low during DOUT write data phase -> DOUT=0 after release, no write applied.

Source files
------------

// File: rtl/ahb3lite_gpio.sv
// AHB3-Lite GPIO slave: zero-wait-state register file with output,
// direction, synchronised inputs and rising-edge interrupt status.
module ahb3lite_gpio #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq_o
);

  localparam int W = GPIO_WIDTH;

  logic         dp_act;
  logic         dp_write;
  logic [2:0]   dp_off;
  logic [2:0]   dp_size;
  logic [1:0]   dp_lo;
  logic         accept;

  logic [W-1:0] dout, dir, ien, istat;
  logic [W-1:0] dout_n, dir_n, ien_n, istat_n;
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_d;
  logic [W-1:0] din, rise, wm, clr, rdv;
  logic [HDATA_SIZE-1:0] lane;
  logic [HDATA_SIZE-1:0] rd;
  logic         we;
  logic         unused_bits;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign gpio_o    = dout;
  assign gpio_oe   = dir;
  assign HRDATA    = rd;
  assign unused_bits = ^{HADDR, HWDATA, HBURST, HPROT, HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act   <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
      dp_size  <= '0;
      dp_lo    <= '0;
    end else if (HREADY) begin
      dp_act   <= accept;
      dp_write <= HWRITE;
      dp_off   <= HADDR[4:2];
      dp_size  <= HSIZE;
      dp_lo    <= HADDR[1:0];
    end
  end

  always_comb begin
    lane = '0;
    unique case (dp_size)
      3'd0:    lane = 32'h0000_00FF << {dp_lo, 3'b000};
      3'd1:    lane = 32'h0000_FFFF << {dp_lo[1], 4'b0000};
      default: lane = '1;
    endcase
  end

  assign we = dp_act & dp_write;
  assign wm = HWDATA[W-1:0] & lane[W-1:0];

  // Pin synchroniser plus one delay flop for edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign din  = sync_q[SYNC_STAGES-1];
  assign rise = din & ~sync_d;

  always_comb begin
    dout_n = dout;
    dir_n  = dir;
    ien_n  = ien;
    clr    = '0;
    if (we) begin
      unique case (dp_off)
        3'd0:    dout_n = (dout & ~lane[W-1:0]) | wm;
        3'd2:    dir_n  = (dir & ~lane[W-1:0]) | wm;
        3'd3:    dout_n = dout | wm;
        3'd4:    dout_n = dout & ~wm;
        3'd5:    dout_n = dout ^ wm;
        3'd6:    ien_n  = (ien & ~lane[W-1:0]) | wm;
        3'd7:    clr    = wm;
        default: ;
      endcase
    end
    // A new rise beats a simultaneous write-1-to-clear
    istat_n = (istat & ~clr) | rise;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dout  <= '0;
      dir   <= '0;
      ien   <= '0;
      istat <= '0;
      irq_o <= 1'b0;
    end else begin
      dout  <= dout_n;
      dir   <= dir_n;
      ien   <= ien_n;
      istat <= istat_n;
      irq_o <= |(istat & ien);
    end
  end

  always_comb begin
    rd  = '0;
    rdv = '0;
    if (dp_act && !dp_write) begin
      unique case (dp_off)
        3'd0:    rdv = dout;
        3'd1:    rdv = din;
        3'd2:    rdv = dir;
        3'd6:    rdv = ien;
        3'd7:    rdv = istat;
        default: rdv = '0;
      endcase
    end
    rd[W-1:0] = rdv;
  end

endmodule

// File: tb/tb_ahb3lite_gpio.sv
// Directed bench for ahb3lite_gpio (16 pins, 2 sync stages).
// Immediate assertions at each check; one summary line at the end.
module tb_ahb3lite_gpio;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic [1:0]  HTRANS = '0;
  logic        HREADYOUT;
  logic        HREADY = 1'b1;
  logic        HRESP;
  logic [15:0] gpio_i = '0;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe;
  logic        irq_o;

  int n_chk = 0;
  int n_fail = 0;

  ahb3lite_gpio #(
    .HADDR_SIZE(32), .HDATA_SIZE(32),
    .GPIO_WIDTH(16), .SYNC_STAGES(2)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HREADYOUT(HREADYOUT),
    .HREADY(HREADY), .HRESP(HRESP), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic w,
                    input logic [2:0] s);
    HSEL = 1'b1; HTRANS = 2'd2; HADDR = a; HWRITE = w; HSIZE = s;
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] s);
    ap(a, 1'b1, s);
    tick();
    HWDATA = d;
    idle();
    tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    ap(a, 1'b0, 3'd2);
    tick();
    idle();
    chk(tag, HRDATA, exp);
    tick();
  endtask

  initial begin
    #3;
    chk("rst_gpio_o", gpio_o, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("hreadyout", HREADYOUT, 1);
    chk("hresp", HRESP, 0);
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    tick();

    // DOUT, DIR back-to-back, then read DIR right after its write
    ap(32'h00, 1'b1, 3'd2);
    tick();
    HWDATA = 32'h0000_00A5;
    ap(32'h08, 1'b1, 3'd2);
    tick();
    chk("dout_a5", gpio_o, 16'h00A5);
    HWDATA = 32'h0000_00FF;
    ap(32'h08, 1'b0, 3'd2);
    tick();
    chk("dir_ff", gpio_oe, 16'h00FF);
    chk("raw_dir", HRDATA, 32'h0000_00FF);
    idle();
    HWDATA = 32'hDEAD_BEEF;
    tick();
    chk("idle_hrdata", HRDATA, 0);
    rd("rd_dout", 32'h00, 32'h0000_00A5);
    rd("rd_set", 32'h0C, 32'h0);

    // SET / CLR / TGL pipelined
    wr(32'h00, 32'h0000_00F0, 3'd2);
    ap(32'h0C, 1'b1, 3'd2);
    tick();
    HWDATA = 32'h01;
    ap(32'h10, 1'b1, 3'd2);
    tick();
    chk("set", gpio_o, 16'h00F1);
    HWDATA = 32'h80;
    ap(32'h14, 1'b1, 3'd2);
    tick();
    chk("clr", gpio_o, 16'h0071);
    HWDATA = 32'h0F;
    idle();
    tick();
    chk("tgl", gpio_o, 16'h007E);

    // Byte / halfword lanes
    wr(32'h01, 32'h0000_3C00, 3'd0);
    chk("byte1", gpio_o, 16'h3C7E);
    wr(32'h00, 32'hFFFF_FF11, 3'd0);
    chk("byte0", gpio_o, 16'h3C11);
    wr(32'h08, 32'hABCD_1234, 3'd1);
    chk("half_lo", gpio_oe, 16'h1234);
    wr(32'h0A, 32'h5678_0000, 3'd1);
    chk("half_hi", gpio_oe, 16'h1234);
    rd("zext", 32'h00, 32'h0000_3C11);

    // Edge detect and interrupt timing
    wr(32'h18, 32'h0000_0008, 3'd2);
    gpio_i = 16'h0009;
    tick();
    tick();
    tick();
    chk("irq_early", irq_o, 0);
    tick();
    chk("irq_set", irq_o, 1);
    rd("istat", 32'h1C, 32'h0000_0009);
    rd("din", 32'h04, 32'h0000_0009);
    wr(32'h04, 32'h0000_FFFF, 3'd2);
    rd("din_ro", 32'h04, 32'h0000_0009);
    wr(32'h1C, 32'h0000_0008, 3'd2);
    tick();
    chk("irq_clr", irq_o, 0);
    rd("istat_w1c", 32'h1C, 32'h0000_0001);

    // Rise on pin 2 in the same cycle as its clear
    gpio_i = 16'h000D;
    tick();
    ap(32'h1C, 1'b1, 3'd2);
    tick();
    HWDATA = 32'h0000_0005;
    idle();
    tick();
    rd("set_wins", 32'h1C, 32'h0000_0004);
    chk("irq_masked", irq_o, 0);

    // Reset during a DOUT write data phase
    ap(32'h00, 1'b1, 3'd2);
    tick();
    HWDATA = 32'h0000_1234;
    idle();
    #2 HRESETn = 1'b0;
    #1 chk("async_rst", gpio_o, 0);
    #2 HRESETn = 1'b1;
    tick();
    chk("no_write", gpio_o, 0);
    chk("dir_rst", gpio_oe, 0);
    rd("istat_pre", 32'h1C, 32'h0);
    rd("istat_rel", 32'h1C, 32'h0000_000D);
    rd("ien_rst", 32'h18, 32'h0);
    chk("irq_rst", irq_o, 0);
    wr(32'h00, 32'h0000_0055, 3'd2);
    chk("post_rst", gpio_o, 16'h0055);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
